csa_pipe_adder: RTL

//  Parametrised, pipelined carry-select adder; next generation of the 8-bit CSA.

---
 rtl/csa_pkg.sv | 54 +++++
 rtl/csa_segment.sv | 69 ++++++
 rtl/csa_pipe_adder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder: default geometry,
// parameter legality check, default-size stage payload and a segment-level
// reference model of the carry-select add.
package csa_pkg;

  localparam int CSA_WIDTH  = 32;
  localparam int CSA_STAGES = 4;
  localparam int CSA_BLK    = 4;
  localparam int CSA_SEG    = CSA_WIDTH / CSA_STAGES;

  // Geometry is legal when the word splits evenly into segments and every
  // segment splits evenly into carry-select blocks.
  function automatic bit csa_params_ok(input int width, input int stages, input int blk);
    if (width <= 0 || stages <= 0 || blk <= 0) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    return ((width / stages) % blk) == 0;
  endfunction

  // Payload carried by one pipeline stage in the default geometry: the
  // operand slices not yet added, the sum slices already finished and the
  // carry handed to the next segment.
  typedef struct packed {
    logic                 valid;
    logic                 sub;
    logic                 carry;
    logic                 ovf;
    logic [CSA_WIDTH-1:0] a;
    logic [CSA_WIDTH-1:0] b;
    logic [CSA_WIDTH-1:0] s;
  } csa_stage_t;

  // Reference carry-select add of one default-size segment; returns {cout, s}.
  function automatic logic [CSA_SEG:0] seg_add_csa(input logic [CSA_SEG-1:0] a,
                                                   input logic [CSA_SEG-1:0] b,
                                                   input logic               cin);
    logic [CSA_SEG-1:0] s;
    logic [CSA_BLK-1:0] s0;
    logic [CSA_BLK-1:0] s1;
    logic               c;
    logic               c0;
    logic               c1;
    s = '0;
    c = cin;
    for (int j = 0; j < CSA_SEG / CSA_BLK; j++) begin
      {c0, s0} = {1'b0, a[j*CSA_BLK +: CSA_BLK]} + {1'b0, b[j*CSA_BLK +: CSA_BLK]};
      {c1, s1} = {1'b0, a[j*CSA_BLK +: CSA_BLK]} + {1'b0, b[j*CSA_BLK +: CSA_BLK]}
                 + (CSA_BLK+1)'(1);
      s[j*CSA_BLK +: CSA_BLK] = c ? s1 : s0;
      c = c ? c1 : c0;
    end
    return {c, s};
  endfunction

endpackage

// File: rtl/csa_segment.sv
// Combinational SEG-bit carry-select adder. Block 0 ripples on the incoming
// carry; every other block computes its sum for carry 0 and carry 1 up front
// and the real block carry only drives a mux. c_msb_in is the carry into the
// segment MSB, used by the top level for signed overflow.
module csa_segment
  import csa_pkg::*;
#(
  parameter int SEG = 8,
  parameter int BLK = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  localparam int NBLK = SEG / BLK;

  // Ripple add of one block; returns {carry out, carry into block MSB, sum}.
  function automatic logic [BLK+1:0] blk_add(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           ci);
    logic [BLK-1:0] sv;
    logic           c;
    logic           cm;
    sv = '0;
    c  = ci;
    cm = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      if (i == BLK - 1) cm = c;
      sv[i] = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, cm, sv};
  endfunction

  logic [BLK+1:0] r0;
  logic [BLK+1:0] r1;
  logic [BLK+1:0] rs;
  logic           bc;

  // Walk the blocks: ripple block 0, select precomputed results for the rest.
  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path through this block can infer a latch.
    s        = '0;
    cout     = 1'b0;
    c_msb_in = 1'b0;
    r0       = '0;
    r1       = '0;
    rs       = '0;
    bc       = cin;
    for (int j = 0; j < NBLK; j++) begin
      if (j == 0) begin
        rs = blk_add(a[BLK-1:0], b[BLK-1:0], cin);
      end else begin
        r0 = blk_add(a[j*BLK +: BLK], b[j*BLK +: BLK], 1'b0);
        r1 = blk_add(a[j*BLK +: BLK], b[j*BLK +: BLK], 1'b1);
        rs = bc ? r1 : r0;
      end
      s[j*BLK +: BLK] = rs[BLK-1:0];
      c_msb_in        = rs[BLK];
      bc              = rs[BLK+1];
    end
    cout = bc;
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined WIDTH-bit carry-select adder with valid/ready on both sides.
// Stage k adds bits [k*SEG +: SEG]; the carry is registered between stages
// while unfinished operand slices and finished sum slices travel alongside.
// One global enable stalls the whole pipe when the output is held, giving
// full throughput with backpressure and a fixed latency of STAGES cycles.
// Optional build macro: CSA_SUB_EN adds the op_sub port (1 = A - B).
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int STAGES = CSA_STAGES,
  parameter int BLK    = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef CSA_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (!csa_params_ok(WIDTH, STAGES, BLK)) begin : g_bad_params
    $error("csa_pipe_adder: WIDTH must split into STAGES segments, each a multiple of BLK");
  end

  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  logic   sub_in;
  logic   en;
  stage_t head;
  stage_t stg_d [STAGES];
  stage_t stg_q [STAGES];

`ifdef CSA_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif

  // The whole pipe moves together unless a result is waiting to be taken.
  assign en        = !stg_q[STAGES-1].valid || out_ready;
  assign in_ready  = en;
  assign out_valid = stg_q[STAGES-1].valid;
  assign sum       = stg_q[STAGES-1].s;
  assign carry     = stg_q[STAGES-1].carry;
  assign ovf       = stg_q[STAGES-1].ovf;

  // Payload entering stage 0; subtraction forces the carry-in to 1.
  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.sub   = sub_in;
    head.carry = sub_in | cin;
    head.a     = A;
    head.b     = B;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         prv;
    stage_t         nxt;
    logic [SEG-1:0] seg_s;
    logic           seg_cout;
    logic           seg_cmsb;

    if (k == 0) begin : g_first
      assign prv = head;
    end else begin : g_next
      assign prv = stg_q[k-1];
    end

    // The subtract flag travels with the op, so each segment inverts its own B slice.
    csa_segment #(
      .SEG (SEG),
      .BLK (BLK)
    ) u_seg (
      .a        (prv.a[k*SEG +: SEG]),
      .b        (prv.b[k*SEG +: SEG] ^ {SEG{prv.sub}}),
      .cin      (prv.carry),
      .s        (seg_s),
      .cout     (seg_cout),
      .c_msb_in (seg_cmsb)
    );

    // Merge this segment's sum slice and carry into the payload for stage k.
    always_comb begin
      nxt                  = prv;
      nxt.s[k*SEG +: SEG]  = seg_s;
      nxt.carry            = seg_cout;
      nxt.ovf              = seg_cmsb ^ seg_cout;
    end

    assign stg_d[k] = nxt;
  end

  // Stage registers: hold on stall, load payload on valid, drop only the valid bit on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data fields are reset along with the valids so a flushed pipe shows sum/carry/ovf of zero, not stale operands.
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        // NOTE: non-blocking assignments here, so every stage samples its predecessor's pre-edge value.
        if (stg_d[k].valid) stg_q[k] <= stg_d[k];
        else                stg_q[k].valid <= 1'b0;
      end
    end
  end

endmodule
